// File: rtl/seq_code_lock_pkg.sv
// Shared types and width helpers for the serial code lock.
//   lock_state_e : FSM state encoding (all four 2-bit codes are used)
//   clog2w       : ceil(log2(v)) clamped to at least 1 so zero-width vectors never occur
//   max_int      : larger of two integers, used to size the shared hold timer
package seq_lock_pkg;

    typedef enum logic [1:0] {
        ENTRY    = 2'd0,
        UNLOCKED = 2'd1,
        LOCKOUT  = 2'd2,
        ALARM    = 2'd3
    } lock_state_e;

    function automatic int clog2w(input int v);
        int r;
        r = $clog2(v);
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seq_code_lock_if.sv
// Symbol/code/status bundle between the keypad front-end and the code lock.
//   master : front-end side, drives sym_valid/sym/code_load/code_in, reads status
//   slave  : lock side, reads symbols and code loads, drives
//            unlocked/locked_out/alarm/progress/tries_left
interface seq_code_lock_if #(
    parameter int SYM_W     = 1,
    parameter int CODE_LEN  = 4,
    parameter int MAX_TRIES = 3
);
    import seq_lock_pkg::*;

    localparam int PW = clog2w(CODE_LEN + 1);
    localparam int FW = clog2w(MAX_TRIES + 1);

    logic                      sym_valid;
    logic [SYM_W-1:0]          sym;
    logic                      code_load;
    logic [CODE_LEN*SYM_W-1:0] code_in;
    logic                      unlocked;
    logic                      locked_out;
    logic                      alarm;
    logic [PW-1:0]             progress;
    logic [FW-1:0]             tries_left;

    modport master (
        output sym_valid, sym, code_load, code_in,
        input  unlocked, locked_out, alarm, progress, tries_left
    );

    modport slave (
        input  sym_valid, sym, code_load, code_in,
        output unlocked, locked_out, alarm, progress, tries_left
    );

endinterface

// File: rtl/seq_code_lock_timer.sv
// Loadable down-counter shared by the unlock hold and the lockout.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (value -> 0)
//   load       : take load_val at this edge (wins over counting)
//   load_val   : value to load (hold length minus one)
//   value      : current count; stops at zero
//   zero       : value == 0
module lock_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         zero
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (value != '0) begin
            value <= value - W'(1);
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/seq_code_lock.sv
// Serial code lock: matches valid-qualified symbols against a programmable
// CODE_LEN-symbol code. A full match opens the lock for UNLOCK_CYC cycles, a
// mismatch ignores input for LOCKOUT_CYC cycles, and MAX_TRIES consecutive
// mismatches latch the alarm until reset.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : seq_code_lock_if.slave (symbols, code load, status outputs)
//
// state    | meaning
// ENTRY    | comparing incoming symbols against code[progress]
// UNLOCKED | lock open, hold timer running, code_load honoured
// LOCKOUT  | wrong entry, input ignored while timer runs
// ALARM    | too many failures, terminal until reset
module seq_code_lock
    import seq_lock_pkg::*;
#(
    parameter int                          SYM_W        = 1,
    parameter int                          CODE_LEN     = 4,
    parameter logic [CODE_LEN*SYM_W-1:0]   DEFAULT_CODE = '0,
    parameter int                          UNLOCK_CYC   = 10,
    parameter int                          LOCKOUT_CYC  = 16,
    parameter int                          MAX_TRIES    = 3
) (
    input logic           clk,
    input logic           reset,
    seq_code_lock_if.slave bus
);

    localparam int PW = clog2w(CODE_LEN + 1);
    localparam int FW = clog2w(MAX_TRIES + 1);
    localparam int TW = clog2w(max_int(UNLOCK_CYC, LOCKOUT_CYC));

    localparam logic [TW-1:0] UNLOCK_LD  = TW'(UNLOCK_CYC - 1);
    localparam logic [TW-1:0] LOCKOUT_LD = TW'(LOCKOUT_CYC - 1);

    lock_state_e               state_r, state_n;
    logic [CODE_LEN*SYM_W-1:0] code_r;
    logic [PW-1:0]             progress_r, progress_n;
    logic [FW-1:0]             fail_r, fail_n, fail_inc;
    logic [SYM_W-1:0]          cur_sym;
    logic                      tmr_load;
    logic [TW-1:0]             tmr_val;
    logic [TW-1:0]             tmr_value;
    logic                      tmr_zero;

    lock_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .value    (tmr_value),
        .zero     (tmr_zero)
    );

    // Symbol expected next; a loop avoids an out-of-range part-select if
    // progress ever holds a value >= CODE_LEN.
    always_comb begin
        cur_sym = '0;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (int'(progress_r) == i) cur_sym = code_r[i*SYM_W +: SYM_W];
        end
    end

    assign fail_inc = fail_r + FW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ENTRY;
            progress_r <= '0;
            fail_r     <= '0;
        end else begin
            state_r    <= state_n;
            progress_r <= progress_n;
            fail_r     <= fail_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_r <= DEFAULT_CODE;
        end else if (state_r == UNLOCKED && bus.code_load) begin
            code_r <= bus.code_in;
        end
    end

    always_comb begin
        state_n    = state_r;
        progress_n = progress_r;
        fail_n     = fail_r;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        case (state_r)
            ENTRY: begin
                if (bus.sym_valid) begin
                    if (bus.sym == cur_sym) begin
                        if (progress_r == PW'(CODE_LEN - 1)) begin
                            state_n    = UNLOCKED;
                            progress_n = '0;
                            fail_n     = '0;
                            tmr_load   = 1'b1;
                            tmr_val    = UNLOCK_LD;
                        end else begin
                            progress_n = progress_r + PW'(1);
                        end
                    end else begin
                        progress_n = '0;
                        fail_n     = fail_inc;
                        if (fail_inc == FW'(MAX_TRIES)) begin
                            state_n = ALARM;
                        end else begin
                            state_n  = LOCKOUT;
                            tmr_load = 1'b1;
                            tmr_val  = LOCKOUT_LD;
                        end
                    end
                end
            end
            UNLOCKED: begin
                if (tmr_zero) state_n = ENTRY;
            end
            LOCKOUT: begin
                if (tmr_zero) begin
                    state_n    = ENTRY;
                    progress_n = '0;
                end
            end
            ALARM: begin
            end
            default: begin
                state_n    = ENTRY;
                progress_n = '0;
            end
        endcase
    end

    assign bus.unlocked   = (state_r == UNLOCKED);
    assign bus.locked_out = (state_r == LOCKOUT);
    assign bus.alarm      = (state_r == ALARM);
    assign bus.progress   = progress_r;
    assign bus.tries_left = FW'(MAX_TRIES) - fail_r;

endmodule

// File: tb/tb_seq_code_lock.sv
module tb_seq_code_lock;
    import seq_lock_pkg::*;

    logic clk;
    logic rst1, rst4;

    seq_code_lock_if #(.SYM_W(1), .CODE_LEN(4), .MAX_TRIES(3)) b1 ();
    seq_code_lock_if #(.SYM_W(4), .CODE_LEN(4), .MAX_TRIES(3)) b4 ();

    seq_code_lock dut1 (.clk(clk), .reset(rst1), .bus(b1.slave));
    seq_code_lock #(.SYM_W(4)) dut4 (.clk(clk), .reset(rst4), .bus(b4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] v;
    } exp_t;

    exp_t sbq[$];
    int   tests  = 0;
    int   failed = 0;

    // {unlocked, locked_out, alarm, progress[2:0], tries_left[1:0]}
    function automatic logic [7:0] ex(input bit u, input bit l, input bit a,
                                      input int p, input int t);
        return {u, l, a, 3'(p), 2'(t)};
    endfunction

    task automatic check(input int w);
        exp_t       e;
        logic [7:0] obs;
        tests++;
        if (sbq.size() == 0) begin
            failed++;
            $error("FAIL sb_empty observed=none expected=entry");
            return;
        end
        e = sbq.pop_front();
        if (w == 1) obs = {b1.unlocked, b1.locked_out, b1.alarm, b1.progress, b1.tries_left};
        else        obs = {b4.unlocked, b4.locked_out, b4.alarm, b4.progress, b4.tries_left};
        assert (obs === e.v)
        else begin
            failed++;
            $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.v);
        end
    endtask

    task automatic drive(input int w, input bit v, input logic [3:0] s,
                         input bit cl, input logic [15:0] ci);
        if (w == 1) begin
            b1.sym_valid = v; b1.sym = s[0]; b1.code_load = cl; b1.code_in = ci[3:0];
        end else begin
            b4.sym_valid = v; b4.sym = s; b4.code_load = cl; b4.code_in = ci;
        end
    endtask

    task automatic step(input int w, input bit v, input logic [3:0] s,
                        input bit cl, input logic [15:0] ci,
                        input logic [7:0] e, input string tag);
        drive(w, v, s, cl, ci);
        sbq.push_back('{tag, e});
        @(posedge clk);
        #1;
        check(w);
    endtask

    task automatic hold(input int w, input int n, input bit v, input logic [3:0] s,
                        input bit cl, input logic [15:0] ci,
                        input logic [7:0] e, input string tag);
        for (int i = 0; i < n; i++) step(w, v, s, cl, ci, e, tag);
    endtask

    task automatic reset_check(input int w, input string tag);
        drive(1, 0, 0, 0, 0);
        drive(4, 0, 0, 0, 0);
        if (w == 1) rst1 = 1'b1; else rst4 = 1'b1;
        sbq.push_back('{tag, ex(0, 0, 0, 0, 3)});
        #2;
        check(w);
        #2;
        rst1 = 1'b0;
        rst4 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic unlock_entry(input int w, input string tag);
        step(w, 1, 0, 0, 0, ex(0, 0, 0, 1, 3), {tag, "_p1"});
        step(w, 1, 0, 0, 0, ex(0, 0, 0, 2, 3), {tag, "_p2"});
        step(w, 1, 0, 0, 0, ex(0, 0, 0, 3, 3), {tag, "_p3"});
        step(w, 1, 0, 0, 0, ex(1, 0, 0, 0, 3), {tag, "_unl"});
    endtask

    initial begin
        rst1 = 1'b1;
        rst4 = 1'b1;
        drive(1, 0, 0, 0, 0);
        drive(4, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        sbq.push_back('{"reset1", ex(0, 0, 0, 0, 3)});
        check(1);
        sbq.push_back('{"reset4", ex(0, 0, 0, 0, 3)});
        check(4);
        #3;
        rst1 = 1'b0;
        rst4 = 1'b0;
        @(posedge clk);
        #1;

        // correct entry, wrong symbols during hold ignored, exactly 10 cycles
        unlock_entry(1, "ok");
        hold(1, 9, 1, 1, 0, 0, ex(1, 0, 0, 0, 3), "ok_hold");
        step(1, 0, 0, 0, 0, ex(0, 0, 0, 0, 3), "ok_exit");

        // gaps inside the entry
        step(1, 1, 0, 0, 0, ex(0, 0, 0, 1, 3), "gap_p1");
        step(1, 0, 1, 0, 0, ex(0, 0, 0, 1, 3), "gap_hold1");
        step(1, 1, 0, 0, 0, ex(0, 0, 0, 2, 3), "gap_p2");
        step(1, 0, 1, 0, 0, ex(0, 0, 0, 2, 3), "gap_hold2");
        step(1, 0, 0, 0, 0, ex(0, 0, 0, 2, 3), "gap_hold3");
        step(1, 1, 0, 0, 0, ex(0, 0, 0, 3, 3), "gap_p3");
        step(1, 1, 0, 0, 0, ex(1, 0, 0, 0, 3), "gap_unl");
        hold(1, 9, 0, 0, 0, 0, ex(1, 0, 0, 0, 3), "gap_hold");
        step(1, 0, 0, 0, 0, ex(0, 0, 0, 0, 3), "gap_exit");

        // wrong entry 0,0,1 -> 16-cycle lockout, symbols ignored
        step(1, 1, 0, 0, 0, ex(0, 0, 0, 1, 3), "w1_p1");
        step(1, 1, 0, 0, 0, ex(0, 0, 0, 2, 3), "w1_p2");
        step(1, 1, 1, 0, 0, ex(0, 1, 0, 0, 2), "w1_lock");
        hold(1, 15, 1, 0, 0, 0, ex(0, 1, 0, 0, 2), "w1_hold");
        step(1, 1, 0, 0, 0, ex(0, 0, 0, 0, 2), "w1_exit");

        // second and third consecutive failures -> alarm
        step(1, 1, 1, 0, 0, ex(0, 1, 0, 0, 1), "w2_lock");
        hold(1, 15, 1, 0, 0, 0, ex(0, 1, 0, 0, 1), "w2_hold");
        step(1, 0, 0, 0, 0, ex(0, 0, 0, 0, 1), "w2_exit");
        step(1, 1, 1, 0, 0, ex(0, 0, 1, 0, 0), "w3_alarm");
        hold(1, 6, 1, 0, 1, 0, ex(0, 0, 1, 0, 0), "alarm_sticky");
        reset_check(1, "rst_alarm");

        // reset during unlock hold and during lockout
        unlock_entry(1, "ru");
        hold(1, 3, 0, 0, 0, 0, ex(1, 0, 0, 0, 3), "ru_hold");
        reset_check(1, "rst_unlock");
        step(1, 1, 1, 0, 0, ex(0, 1, 0, 0, 2), "rl_lock");
        hold(1, 4, 0, 0, 0, 0, ex(0, 1, 0, 0, 2), "rl_hold");
        reset_check(1, "rst_lockout");
        unlock_entry(1, "post_rst");

        // SYM_W=4: code_load ignored in ENTRY, honoured while unlocked
        step(4, 0, 0, 1, 16'h4321, ex(0, 0, 0, 0, 3), "ld_entry");
        unlock_entry(4, "ld_dflt");
        step(4, 0, 0, 1, 16'h4321, ex(1, 0, 0, 0, 3), "ld_unl");
        hold(4, 8, 0, 0, 0, 0, ex(1, 0, 0, 0, 3), "ld_hold");
        step(4, 0, 0, 0, 0, ex(0, 0, 0, 0, 3), "ld_exit");
        step(4, 1, 4'h1, 0, 0, ex(0, 0, 0, 1, 3), "new_p1");
        step(4, 1, 4'h2, 0, 0, ex(0, 0, 0, 2, 3), "new_p2");
        step(4, 1, 4'h3, 0, 0, ex(0, 0, 0, 3, 3), "new_p3");
        step(4, 1, 4'h4, 0, 0, ex(1, 0, 0, 0, 3), "new_unl");
        hold(4, 9, 0, 0, 0, 0, ex(1, 0, 0, 0, 3), "new_hold");
        step(4, 0, 0, 0, 0, ex(0, 0, 0, 0, 3), "new_exit");
        step(4, 1, 4'h0, 0, 0, ex(0, 1, 0, 0, 2), "old_code_fail");
        hold(4, 15, 0, 0, 0, 0, ex(0, 1, 0, 0, 2), "old_hold");
        step(4, 0, 0, 0, 0, ex(0, 0, 0, 0, 2), "old_exit");
        reset_check(4, "rst4");
        unlock_entry(4, "dflt_back");

        if (sbq.size() != 0) begin
            tests++;
            failed++;
            $error("FAIL sb_leftover observed=%0d expected=0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
